wr_ptr_ctrl: RTL
================

# wr_ptr_ctrl

Write-side pointer controller for the asynchronous FIFO. It replaces the plain binary write pointer with a registered Gray-coded pointer for clock-domain crossing. It derives `full` locally from the synchronised read pointer and adds an almost-full flag, a fill-level estimate and a sticky overflow flag. It sits in the `wr_clk` domain between the system writer, the dual-port RAM write port and the read-to-write pointer synchroniser.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: RAM address width; DEPTH = 2**ADDR_WIDTH.
- `AF_THRESH`, 2**ADDR_WIDTH-2: almost-full level. Legal range 1..DEPTH; out of range is an elaboration error.

Ports:
- `wr_clk`  in  1: write-domain clock. This block has one clock.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: write request from the system.
- `rd_ptr_gray_sync`  in  ADDR_WIDTH+1: read Gray pointer, already 2-flop synchronised into `wr_clk`.
- `ovf_clr`  in  1: clears `overflow`.
- `ram_wen`  out  1: RAM write enable.
- `wr_addr`  out  ADDR_WIDTH: RAM write address.
- `wr_ptr_gray`  out  ADDR_WIDTH+1: registered Gray write pointer, sent to the synchroniser.
- `full`  out  1: FIFO full.
- `almost_full`  out  1: fill level >= AF_THRESH.
- `wr_level`  out  ADDR_WIDTH+1: fill-level estimate, 0..DEPTH.
- `overflow`  out  1: sticky; a write was attempted while full.

## Operation
- Accept: `ram_wen = wr_en & ~full`. This is combinational from registered `full`.
- `wr_bin` is an (ADDR_WIDTH+1)-bit binary register; `wr_bin_next = wr_bin + ram_wen`, modulo 2**(ADDR_WIDTH+1). It wraps naturally.
- `wr_addr = wr_bin[ADDR_WIDTH-1:0]`.
- `wr_ptr_gray` register <= `wr_bin_next ^ (wr_bin_next >> 1)`. It is never a combinational output and changes at most one bit per cycle.
- `full` register <= (Gray(`wr_bin_next`) == {~rd[AW:AW-1], rd[AW-2:0]}), where rd = `rd_ptr_gray_sync`. For ADDR_WIDTH=1 the comparison is {~rd[1:0]}.
- `rd_bin = gray2bin(rd_ptr_gray_sync)`. `wr_level` register <= `wr_bin_next - rd_bin`, modulo 2**(ADDR_WIDTH+1).
- `almost_full` register <= (`wr_bin_next - rd_bin`) >= AF_THRESH.
- `overflow` register: set when `wr_en & full`; else cleared when `ovf_clr`; else held. Set wins over clear in the same cycle.
- When `wr_en` is asserted while full: nothing is written and the pointer holds.
- Flags are pessimistic. A read seen on `rd_ptr_gray_sync` deasserts `full`/`almost_full` and lowers `wr_level` on the next edge. A write raises them on the same edge as the pointer update.

## Timing
- Reset: on any `wr_clk` edge with `rst`=1, all registers clear to 0. That gives `wr_addr`=0, `wr_ptr_gray`=0, `full`=0, `almost_full`=0, `wr_level`=0, `overflow`=0.
  - `ram_wen`=0 during reset. `full` is 0, so `ram_wen` is additionally gated by `~rst`.
  - Reset mid-operation discards the fill state. The reader side is reset together by the system.
- Write latency: a write accepted at edge N updates `wr_addr`, `wr_ptr_gray`, `wr_level`, `full` and `almost_full` at edge N+1 (visible in cycle N+1).
- Simultaneous accepted write and read-pointer change in one cycle: the flags use `wr_bin_next` and the current `rd_ptr_gray_sync`. The result is exact for the sampled values.
- Back-to-back writes: one per cycle, sustained until `full`.
- Pointer wrap from 2**(ADDR_WIDTH+1)-1 to 0 is legal. `wr_level` stays correct through the wrap.

## Structure
- Shared package `fifo_pkg` holds:
  - the `bin2gray` and `gray2bin` functions;
  - the full-compare helper;
  - the `ADDR_WIDTH` default.
  The read-side controller reuses all of these.
- One sub-module is natural: `gray2bin_conv` (parametrised width, combinational), instantiated on `rd_ptr_gray_sync`.
- Everything else is flat in `wr_ptr_ctrl`. Expected size is about 150–250 lines.

## Test plan
All scenarios use ADDR_WIDTH=4 and AF_THRESH=14.
- **Reset:** hold `rst` 3 cycles with `wr_en`=1 -> all outputs 0 and `ram_wen`=0. Release -> first write at `wr_addr`=0.
- **Fill:** `rd_ptr_gray_sync`=0, `wr_en`=1 for 20 cycles.
  - `almost_full` rises the cycle after the 14th accept (`wr_level`=14).
  - `full` rises after the 16th accept, with `wr_level`=16 and `wr_ptr_gray`=5'b11000.
  - `ram_wen`=0 for cycles 17–20.
- **Overflow:** continuing from Fill, `overflow`=1 from the cycle after the 17th request and holds. Pulse `ovf_clr` with `wr_en`=0 -> `overflow`=0 next cycle. `ovf_clr` together with `wr_en` while full -> `overflow` stays 1.
- **Drain/wrap:** at full, drive `rd_ptr_gray_sync`=5'b11000 -> next cycle `full`=0, `almost_full`=0, `wr_level`=0. Then 16 more writes with read tracking -> pointer wraps to 0, Gray output has one bit change per step.
- **Simultaneous:** `wr_level`=15, write accepted while `rd_ptr_gray_sync` advances by 1 -> `wr_level`=15, `full`=0, `almost_full`=1.
- **Reset mid-fill:** at `wr_level`=9, assert `rst` one cycle with `wr_en`=1 -> next cycle `wr_level`=0, `wr_ptr_gray`=0, no RAM write in the reset cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers for the write- and read-side controllers.
// The functions take 32-bit vectors; callers zero-extend and truncate at their own width.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int unsigned i = 32; i > 0; i--) begin
      acc      = acc ^ g[i-1];
      b[i-1]   = acc;
    end
    return b;
  endfunction

  // Full when the Gray pointers differ only in their top two bits.
  function automatic logic ptr_full(input logic [31:0] wr_gray,
                                    input logic [31:0] rd_gray,
                                    input int unsigned aw);
    return wr_gray == (rd_gray ^ (32'd3 << (aw - 1)));
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of parametrised width.
module gray2bin_conv #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = W; i > 0; i--) begin
      acc      = acc ^ gray[i-1];
      bin[i-1] = acc;
    end
  end

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer controller of the async FIFO: registered Gray pointer,
// locally derived full/almost-full, fill-level estimate and sticky overflow.
module wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  ovf_clr,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("wr_ptr_ctrl: AF_THRESH out of range 1..DEPTH");
  end

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] level_next;

  gray2bin_conv #(.W(PW)) u_rd_g2b (
    .gray (rd_ptr_gray_sync),
    .bin  (rd_bin)
  );

  // full is registered, so the accept path is a single gate deep.
  assign ram_wen     = wr_en & ~full & ~rst;
  assign wr_bin_next = wr_bin + PW'(ram_wen);
  assign level_next  = wr_bin_next - rd_bin;
  assign wr_addr     = wr_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= PW'(bin2gray(32'(wr_bin_next)));
      full        <= ptr_full(bin2gray(32'(wr_bin_next)), 32'(rd_ptr_gray_sync), ADDR_WIDTH);
      almost_full <= 32'(level_next) >= AF_THRESH;
      wr_level    <= level_next;
      if (wr_en && full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule
